// File: rtl/board_pkg.sv
// Shared constants, state encoding and start-board patterns for the game-board memory.
package board_pkg;

  localparam int ROWS_DEF   = 6;
  localparam int COLS_DEF   = 6;
  localparam int CELL_W_DEF = 2;
  localparam int NCELL_DEF  = ROWS_DEF * COLS_DEF;

  localparam int CELL_SUB = 0;
  localparam int CELL_HIT = 1;

  // Standard start boards; bit i is the submarine bit of cell i = x*COLS + y.
  localparam logic [NCELL_DEF-1:0] PAT_BOARD_0 = 36'h0_0000_0003;
  localparam logic [NCELL_DEF-1:0] PAT_BOARD_1 = 36'h8_0410_4001;
  localparam logic [NCELL_DEF-1:0] PAT_BOARD_2 = 36'h0_C003_0C00;
  localparam logic [NCELL_DEF-1:0] PAT_BOARD_3 = 36'h1_0020_0841;

  typedef enum logic [0:0] {
    READY = 1'b0,
    INIT  = 1'b1
  } state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/board_mem_arb_if.sv
// Request/grant and response bundle between the board memory and its requester ports.
interface board_mem_arb_if #(
  parameter int NPORTS = 2,
  parameter int XW     = 3,
  parameter int YW     = 3,
  parameter int CELL_W = 2,
  parameter int PW     = 1
);

  logic [NPORTS-1:0]        req;
  logic [NPORTS-1:0]        wr;
  logic [NPORTS*XW-1:0]     x;
  logic [NPORTS*YW-1:0]     y;
  logic [NPORTS*CELL_W-1:0] wdata;
  logic [NPORTS-1:0]        gnt;
  logic [CELL_W-1:0]        rdata;
  logic                     rvalid;
  logic [PW-1:0]            rport;
  logic                     err;

  modport master (
    output req, wr, x, y, wdata,
    input  gnt, rdata, rvalid, rport, err
  );

  modport slave (
    input  req, wr, x, y, wdata,
    output gnt, rdata, rvalid, rport, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the rotating pointer, which moves past the winner on advance.
module rr_arbiter
  import board_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found_s;
  int            pos_s;

  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {PW{1'b0}};
    found_s   = 1'b0;
    pos_s     = 0;
    for (int i = 0; i < N; i++) begin
      pos_s = int'(ptr_q) + i;
      pos_s = (pos_s >= N) ? (pos_s - N) : pos_s;
      if (!found_s && req[pos_s]) begin
        found_s        = 1'b1;
        grant[pos_s]   = 1'b1;
        grant_idx      = PW'(pos_s);
      end else begin
        found_s        = found_s;
      end
    end
  end

  assign ptr_d = (grant_idx == PW'(N - 1)) ? {PW{1'b0}} : (grant_idx + PW'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= {PW{1'b0}};
    end else if (advance) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end

endmodule

// File: rtl/board_mem_arb.sv
// Game-board cell store with round-robin port access, pattern-load FSM and a running submarine count.
module board_mem_arb
  import board_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int CELL_W = CELL_W_DEF,
  parameter int NPORTS = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  board_mem_arb_if.slave                   bus,
  input  logic                             init_start,
  input  logic [ROWS*COLS-1:0]             init_pattern,
  output logic                             busy,
  output logic [$clog2(ROWS*COLS+1)-1:0]   sub_count,
  output logic                             empty
);

  localparam int NCELL = ROWS * COLS;
  localparam int XW    = clog2_min1(ROWS);
  localparam int YW    = clog2_min1(COLS);
  localparam int CW    = $clog2(NCELL + 1);
  localparam int PW    = clog2_min1(NPORTS);
  localparam int IW    = clog2_min1(NCELL);

  state_e            state_q;
  state_e            state_d;
  logic [CELL_W-1:0] mem_q [NCELL];
  logic [NCELL-1:0]  pattern_q;
  logic [IW-1:0]     cnt_q;
  logic [CW-1:0]     sub_count_q;
  logic              rvalid_q;
  logic [CELL_W-1:0] rdata_q;
  logic [PW-1:0]     rport_q;
  logic              err_q;

  logic              arb_en_s;
  logic [NPORTS-1:0] req_s;
  logic [NPORTS-1:0] gnt_s;
  logic [PW-1:0]     gidx_s;
  logic              acc_s;
  logic [XW-1:0]     x_s;
  logic [YW-1:0]     y_s;
  logic              wr_s;
  logic [CELL_W-1:0] wdata_s;
  logic              oor_s;
  logic [IW-1:0]     idx_s;
  logic [CELL_W-1:0] old_s;

  // Init has priority: no grant in INIT nor on the cycle that starts a load.
  assign arb_en_s = (state_q == READY) && !init_start;
  assign req_s    = bus.req & {NPORTS{arb_en_s}};
  assign acc_s    = |gnt_s;
  assign bus.gnt  = gnt_s;

  rr_arbiter #(.N(NPORTS)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req_s),
    .advance   (acc_s),
    .grant     (gnt_s),
    .grant_idx (gidx_s)
  );

  assign x_s     = bus.x[int'(gidx_s) * XW +: XW];
  assign y_s     = bus.y[int'(gidx_s) * YW +: YW];
  assign wdata_s = bus.wdata[int'(gidx_s) * CELL_W +: CELL_W];
  assign wr_s    = bus.wr[gidx_s];
  assign oor_s   = (32'(x_s) >= 32'(ROWS)) || (32'(y_s) >= 32'(COLS));
  assign idx_s   = IW'(x_s) * IW'(COLS) + IW'(y_s);
  assign old_s   = mem_q[idx_s];

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:   state_d = init_start ? INIT : READY;
      INIT:    state_d = (cnt_q == IW'(NCELL - 1)) ? READY : INIT;
      default: state_d = READY;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      READY:   busy = 1'b0;
      INIT:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Board contents, load sequencing and the running submarine count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCELL; i++) begin
        mem_q[i] <= {CELL_W{1'b0}};
      end
      pattern_q   <= {NCELL{1'b0}};
      cnt_q       <= {IW{1'b0}};
      sub_count_q <= {CW{1'b0}};
    end else begin
      case (state_q)
        READY: begin
          if (init_start) begin
            pattern_q   <= init_pattern;
            cnt_q       <= {IW{1'b0}};
            sub_count_q <= {CW{1'b0}};
          end else if (acc_s && !oor_s && wr_s) begin
            mem_q[idx_s] <= wdata_s;
            sub_count_q  <= sub_count_q + CW'(wdata_s[CELL_SUB]) - CW'(old_s[CELL_SUB]);
          end else begin
            sub_count_q  <= sub_count_q;
          end
        end
        INIT: begin
          mem_q[cnt_q] <= CELL_W'(pattern_q[cnt_q]);
          sub_count_q  <= sub_count_q + CW'(pattern_q[cnt_q]);
          cnt_q        <= cnt_q + IW'(1);
        end
        default: begin
          cnt_q <= {IW{1'b0}};
        end
      endcase
    end
  end

  // Response of the accepted access, one cycle after the accepting edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= {CELL_W{1'b0}};
      rport_q  <= {PW{1'b0}};
      err_q    <= 1'b0;
    end else if (acc_s) begin
      rvalid_q <= 1'b1;
      rport_q  <= gidx_s;
      if (oor_s) begin
        rdata_q <= {CELL_W{1'b0}};
        err_q   <= 1'b1;
      end else begin
        rdata_q <= old_s;
        err_q   <= 1'b0;
      end
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rport  = rport_q;
  assign bus.err    = err_q;
  assign sub_count  = sub_count_q;
  assign empty      = (sub_count_q == CW'(0)) && !busy;

endmodule

// File: doc/board_mem_arb.md
Name: board_mem_arb

Overview:
- Parametrised game-board memory: ROWS x COLS cells, each CELL_W bits wide. Bit 0 of a cell is "submarine present"; the upper bits are game-defined (e.g. hit/miss marks).
- Serves NPORTS requesters through a round-robin arbiter with a req/gnt handshake.
- Loads a start board from a pattern vector with a sequenced init FSM.
- Keeps a running count of submarine cells, so empty detection needs no full-array scan.
- Replaces the fixed 6x6, 2-port, select-driven board store used by the game controller and player logic.

Parameters:
- ROWS, 6, number of board rows (x coordinate range 0..ROWS-1).
- COLS, 6, number of board columns (y coordinate range 0..COLS-1).
- CELL_W, 2, bits per cell; must be >= 1.
- NPORTS, 2, number of requester ports; must be >= 1.
- Derived localparams (not overridable):
  - XW = max(1,$clog2(ROWS)), YW = max(1,$clog2(COLS)).
  - NCELL = ROWS*COLS, CW = $clog2(NCELL+1), PW = max(1,$clog2(NPORTS)).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  NPORTS  per-port access request.
- wr  in  NPORTS  per-port write enable, qualified by req.
- x  in  NPORTS*XW  per-port row, port p at bits [p*XW +: XW].
- y  in  NPORTS*YW  per-port column, packed the same way.
- wdata  in  NPORTS*CELL_W  per-port write data, packed the same way.
- gnt  out  NPORTS  one-hot grant (combinational); at most one bit set.
- rdata  out  CELL_W  pre-write cell contents of the accepted access.
- rvalid  out  1  rdata/rport/err valid for one cycle.
- rport  out  PW  index of the port whose access produced rdata.
- err  out  1  accepted access had out-of-range coordinates.
- init_start  in  1  request a board load from init_pattern.
- init_pattern  in  NCELL  bit i is the submarine bit of cell i.
- busy  out  1  init in progress.
- sub_count  out  CW  number of cells with bit 0 set.
- empty  out  1  sub_count==0 and not busy.

Behaviour:
- Reset (rstn=0, asynchronous):
  - All cells 0, sub_count 0, state READY, rr pointer 0.
  - rvalid 0, rdata 0, rport 0, err 0.
  - Reset during INIT aborts the load; the board stays all zero.
- FSM states:
  - READY -> INIT when init_start=1. The pattern is latched and the cell counter set to 0.
  - INIT writes cell i = {CELL_W-1 zeros, pattern[i]} on cycle i, one cell per cycle, i = 0..NCELL-1.
  - INIT -> READY after cell NCELL-1 is written, so the load takes exactly NCELL cycles.
  - init_start is ignored while in INIT.
  - On entering INIT, sub_count is cleared, then incremented for every pattern bit that is 1.
- Arbitration, READY only:
  - gnt is zero throughout INIT and on the READY->INIT cycle.
  - Round-robin: the search starts at pointer ptr, and the first p with req[p]=1 at or after ptr (wrapping) is granted.
  - An access is accepted when req[p]&gnt[p]. On acceptance, ptr <= p+1 mod NPORTS.
  - Requesters hold req and their operands until they see gnt. Deasserting early is legal and simply loses the slot.
- Access, executed at the accepting edge:
  - index = x*COLS + y.
  - If x>=ROWS or y>=COLS: no memory change, rdata=0, err=1.
  - Otherwise rdata = old cell value, err=0. If wr, the cell is set to wdata.
  - rvalid=1 and rport=p in the next cycle (read latency 1). rvalid is otherwise 0, and rdata holds its last value.
  - Read-before-write: a write returns the old contents, which lets callers detect a hit in one transaction.
- sub_count update on an in-range write: sub_count + wdata[0] - old[0]. Width CW, never wraps given a single write per cycle.
- Simultaneous init_start and req in READY: init wins, no grant that cycle.
- empty is registered-derived, combinational from sub_count/busy, and is 0 throughout INIT.

Decomposition:
- Shared package board_pkg:
  - Default ROWS/COLS/CELL_W constants.
  - CELL_SUB bit index (0) and CELL_HIT bit index (1).
  - The four standard start-board patterns as NCELL-bit constants.
  - An FSM state enum {READY, INIT}.
- One sub-module: rr_arbiter (parameter N; ports req, advance, grant, grant_idx), holding the rotating pointer.

Test Plan:
- Init load: reset, then init_start with pattern 36'h000000003 (cells 0,1) -> busy=1 for 36 cycles, gnt=0 throughout, then sub_count=2, empty=0.
- Read-before-write: port 0 writes (x=0,y=1,wdata=2'b10) -> next cycle rvalid=1, rport=0, rdata=2'b01. sub_count becomes 1.
- Drain: port 1 writes 2'b10 to cell (0,0) -> rdata=2'b01, sub_count=0, empty=1.
- Round-robin: both ports request continuously for 4 cycles -> grants alternate 0,1,0,1 (starting from ptr=0). Each rvalid carries the matching rport.
- Out of range: port 0 reads (x=6,y=0) -> rvalid=1, err=1, rdata=0, board and sub_count unchanged.
- Reset mid-init: rstn pulse at init cycle 10 -> all cells 0, busy=0, sub_count=0, empty=1, and a subsequent read of (0,0) returns 0.
